// File: rtl/vec_math_pkg.sv
// vec_math_pkg: opcodes, Q-format defaults and the saturating clamp shared by the vector ALU
package vec_math_pkg;
  localparam int WIDTH_DEF = 32;
  localparam int FRAC_DEF = 16;
  localparam int SAT_W = 128;
  typedef enum logic [2:0] {
    OP_ADD   = 3'd0,
    OP_SUB   = 3'd1,
    OP_SCALE = 3'd2,
    OP_DOT   = 3'd3,
    OP_CROSS = 3'd4
  } op_e;
  function automatic logic signed [SAT_W-1:0] sat(input logic signed [SAT_W-1:0] v, input int w);
    logic signed [SAT_W-1:0] hi, lo;
    hi = (SAT_W'(1) <<< (w - 1)) - SAT_W'(1);
    lo = -hi - SAT_W'(1);
    return v > hi ? hi : v < lo ? lo : v;
  endfunction
endpackage

// File: rtl/fx_mul.sv
// fx_mul: registered signed WIDTH x WIDTH -> 2*WIDTH multiply (clk, en, a, b -> p)
module fx_mul import vec_math_pkg::*; #(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic                      clk,
  input  logic                      en,
  input  logic signed [WIDTH-1:0]   a,
  input  logic signed [WIDTH-1:0]   b,
  output logic signed [2*WIDTH-1:0] p
);
  localparam int P = 2 * WIDTH;
  always_ff @(posedge clk)
    if (en) p <= P'(a) * P'(b);
endmodule

// File: rtl/vec_alu_pipe.sv
// vec_alu_pipe: 3-stage elastic 3-vector fixed-point ALU (ADD/SUB/SCALE/DOT/CROSS), valid/ready in and out, tag/ovf/err sideband
module vec_alu_pipe import vec_math_pkg::*; #(
  parameter int WIDTH = WIDTH_DEF,
  parameter int FRAC  = FRAC_DEF,
  parameter int SAT   = 1,
  parameter int TAG_W = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [2:0]              op,
  input  logic signed [WIDTH-1:0] x0,
  input  logic signed [WIDTH-1:0] x1,
  input  logic signed [WIDTH-1:0] x2,
  input  logic signed [WIDTH-1:0] y0,
  input  logic signed [WIDTH-1:0] y1,
  input  logic signed [WIDTH-1:0] y2,
  input  logic [TAG_W-1:0]        in_tag,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [WIDTH-1:0] out0,
  output logic signed [WIDTH-1:0] out1,
  output logic signed [WIDTH-1:0] out2,
  output logic [TAG_W-1:0]        out_tag,
  output logic                    out_ovf,
  output logic                    out_err
);
  localparam int A = WIDTH + 1;
  localparam int L = 2 * WIDTH + 2;
  logic v1, v2, ld1, ld2, ld3;
  logic [2:0] op1, op2;
  logic [TAG_W-1:0] tag1, tag2;
  logic signed [WIDTH-1:0] xr[3], yr[3];
  logic signed [A-1:0] as2[3];
  logic signed [2*WIDTH-1:0] p[3][3];
  logic signed [L-1:0] dot, crs[3], scl[3], ase[3], f[3];
  logic signed [SAT_W-1:0] sv[3];
  logic signed [WIDTH-1:0] r[3];
  logic [2:0] o;
  // a stage loads when empty or when the stage after it loads this cycle
  assign ld3 = !out_valid || out_ready;
  assign ld2 = !v2 || ld3;
  assign ld1 = !v1 || ld2;
  assign in_ready = ld1;
  // every x_i*y_j pair is needed by some opcode, so the nine lanes are fixed
  for (genvar i = 0; i < 3; i++) begin : g_x
    for (genvar j = 0; j < 3; j++) begin : g_y
      fx_mul #(.WIDTH(WIDTH)) u_mul (.clk(clk), .en(ld2), .a(xr[i]), .b(yr[j]), .p(p[i][j]));
    end
  end
  always_ff @(posedge clk) begin
    if (ld1) begin
      op1 <= op;
      tag1 <= in_tag;
      xr <= '{x0, x1, x2};
      yr <= '{y0, y1, y2};
    end
    if (ld2) begin
      op2 <= op1;
      tag2 <= tag1;
      for (int n = 0; n < 3; n++)
        as2[n] <= op1 == OP_SUB ? A'(xr[n]) - A'(yr[n]) : A'(xr[n]) + A'(yr[n]);
    end
  end
  always_comb begin
    dot = (L'(p[0][0]) + L'(p[1][1]) + L'(p[2][2])) >>> FRAC;
    crs[0] = (L'(p[1][2]) - L'(p[2][1])) >>> FRAC;
    crs[1] = (L'(p[2][0]) - L'(p[0][2])) >>> FRAC;
    crs[2] = (L'(p[0][1]) - L'(p[1][0])) >>> FRAC;
    for (int n = 0; n < 3; n++) begin
      scl[n] = L'(p[n][0]) >>> FRAC;
      ase[n] = L'(as2[n]);
      f[n] = (op2 == OP_ADD || op2 == OP_SUB) ? ase[n] :
             op2 == OP_SCALE ? scl[n] :
             op2 == OP_DOT ? (n == 0 ? dot : '0) :
             op2 == OP_CROSS ? crs[n] : '0;
      sv[n] = sat(SAT_W'(f[n]), WIDTH);
      r[n] = SAT != 0 ? WIDTH'(sv[n]) : f[n][WIDTH-1:0];
      o[n] = SAT != 0 ? sv[n] != SAT_W'(f[n]) : L'(r[n]) != f[n];
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      v1 <= 1'b0;
      v2 <= 1'b0;
      out_valid <= 1'b0;
      out0 <= '0;
      out1 <= '0;
      out2 <= '0;
      out_tag <= '0;
      out_ovf <= 1'b0;
      out_err <= 1'b0;
    end else begin
      if (ld1) v1 <= in_valid;
      if (ld2) v2 <= v1;
      if (ld3) begin
        out_valid <= v2;
        out0 <= r[0];
        out1 <= r[1];
        out2 <= r[2];
        out_tag <= tag2;
        out_ovf <= |o;
        out_err <= op2 > OP_CROSS;
      end
    end
  end
endmodule

// File: doc/vec_alu_pipe.md
VEC_ALU_PIPE -- requirements
Module: vec_alu_pipe

Interface
REQ-001 Parameter WIDTH, default 32: signed fixed-point word width of every vector component.
REQ-002 Parameter FRAC, default 16: fractional bits (Q(WIDTH-FRAC).FRAC); legal range 0..WIDTH-1.
REQ-003 Parameter SAT, default 1: 1 = saturate results to WIDTH, 0 = wrap (keep low WIDTH bits).
REQ-004 Parameter TAG_W, default 8: width of the sideband tag carried with each operation.
REQ-005 clk  in  1  single clock, all state on rising edge.
REQ-006 rst  in  1  reset; synchronous, active-high.
REQ-007 in_valid  in  1  operand set presented.
REQ-008 in_ready  out  1  block accepts the operand set this cycle.
REQ-009 op  in  3  opcode: 0 ADD, 1 SUB, 2 SCALE, 3 DOT, 4 CROSS; 5..7 illegal.
REQ-010 x0,x1,x2  in  WIDTH each  vector X, signed.
REQ-011 y0,y1,y2  in  WIDTH each  vector Y, signed; y0 is the scalar for SCALE.
REQ-012 in_tag  in  TAG_W  opaque tag.
REQ-013 out_valid  out  1  result present.
REQ-014 out_ready  in  1  downstream accepts the result.
REQ-015 out0,out1,out2  out  WIDTH each  result vector, signed.
REQ-016 out_tag  out  TAG_W  tag of the operation in out0..2.
REQ-017 out_ovf  out  1  any component saturated (SAT=1) or wrapped (SAT=0).
REQ-018 out_err  out  1  operation carried an illegal opcode.

Function
REQ-019 A transfer occurs on a rising edge with in_valid&&in_ready (input) or out_valid&&out_ready (output).
REQ-020 Three-stage pipeline S1 (register operands, op, tag), S2 (full-precision products/sums), S3 (shift, saturate, output registers); latency is exactly 3 cycles from input transfer to out_valid with no stall.
REQ-021 Each stage holds a valid bit; a stage loads when it is empty or its downstream stage loads/empties in the same cycle; in_ready = !S1.valid || S1 advances (bubbles collapse, no combinational path out_ready->data).
REQ-022 Throughput one operation per cycle while out_ready=1; order preserved; no operation dropped or duplicated under any out_ready pattern.
REQ-023 While out_valid=1 and out_ready=0, out0..2, out_tag, out_ovf, out_err hold stable.
REQ-024 ADD: outN = xN+yN; SUB: outN = xN-yN; computed in WIDTH+1 bits before saturation.
REQ-025 SCALE: outN = (xN*y0) >>> FRAC.
REQ-026 DOT: out0 = (x0*y0 + x1*y1 + x2*y2) >>> FRAC; out1 = out2 = 0.
REQ-027 CROSS: out0 = (x1*y2 - x2*y1) >>> FRAC, out1 = (x2*y0 - x0*y2) >>> FRAC, out2 = (x0*y1 - x1*y0) >>> FRAC.
REQ-028 Products are 2*WIDTH bits, sums 2*WIDTH+2 bits, shift is arithmetic (floor toward minus infinity), applied once after summation.
REQ-029 SAT=1: values above 2^(WIDTH-1)-1 clamp to max, below -2^(WIDTH-1) clamp to min; out_ovf=1 if any component clamped.
REQ-030 SAT=0: low WIDTH bits kept; out_ovf=1 if any component's value differed from its full-precision value.
REQ-031 Illegal op: out0..2 = 0, out_ovf = 0, out_err = 1, tag passed through, occupies a normal pipeline slot.

Reset
REQ-032 With rst=1 at a rising edge: all stage valid bits, out_valid, out0..2, out_tag, out_ovf, out_err become 0; in_ready is 1 in the first cycle after reset deasserts.
REQ-033 Reset mid-operation discards all in-flight operations; no result from before reset appears afterwards.
REQ-034 in_valid during rst=1 is not accepted.

Structure
REQ-035 Package vec_math_pkg holds the opcode enumeration, Q-format defaults (WIDTH, FRAC) and the saturate function.
REQ-036 One sub-module fx_mul (signed WIDTH x WIDTH -> 2*WIDTH product, registered) instantiated per product lane; nine instances.

Verification
REQ-037 ADD x=(1.0,2.0,-3.0) y=(0.5,0.5,0.5) (0x00010000 etc.) -> out=(0x00018000,0x00028000,0xFFFD8000) at cycle+3, ovf=0.
REQ-038 CROSS x=(1,0,0) y=(0,1,0) in Q16.16 -> out=(0,0,0x00010000); DOT x=(1,2,3) y=(4,5,6) -> out0=0x00200000 (32.0), out1=out2=0.
REQ-039 SAT=1 ADD x0=0x7FFFFFFF y0=1 -> out0=0x7FFFFFFF, ovf=1; SAT=0 same -> out0=0x80000000, ovf=1.
REQ-040 Back-to-back 16 ops with tags 0..15, out_ready random 50% -> all 16 results in tag order, outputs stable while stalled, in_ready low only when full.
REQ-041 op=6 tag=0xA5 -> out=(0,0,0), err=1, out_tag=0xA5; rst asserted with 3 ops in flight -> out_valid=0 next cycle, none emerge.
